// File: rtl/alu_pkg.sv
// Shared ALU types: NZVC flag layout and add/sub opcode.
package alu_pkg;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } flags_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CW-bit adder slice with carry-in, carry-out and carry into its MSB.
module addsub_chunk #(
   parameter int CW = 16
) (
   input  logic [CW-1:0] x,
   input  logic [CW-1:0] y,
   input  logic          cin,
   output logic [CW-1:0] sum,
   output logic          cout,
   output logic          cmsb
);

   logic [CW:0] full;

   assign full = {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, cin};
   assign sum  = full[CW-1:0];
   assign cout = full[CW];
   // The MSB sum bit is x^y^carry_in, so the carry into it falls out by XOR.
   assign cmsb = x[CW-1] ^ y[CW-1] ^ sum[CW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined BITS-wide add/subtract: one CW-bit carry chunk per stage, NZVC flags, valid/ready at both ends.
module pipelined_addsub
   import alu_pkg::*;
#(
   parameter int BITS   = 64,
   parameter int STAGES = 4,
   parameter int TAG_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BITS-1:0]  a,
   input  logic [BITS-1:0]  b,
   input  logic             sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BITS-1:0]  result,
   output logic [3:0]       flags,
   output logic [TAG_W-1:0] out_tag
);

   localparam int CW = BITS / STAGES;

   logic              cin0;
   logic [STAGES:0]   rdy;
   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] src_vld;

   logic [BITS-1:0]  a_p     [STAGES];
   logic [BITS-1:0]  b_p     [STAGES];
   logic [BITS-1:0]  res_p   [STAGES];
   logic             cy_p    [STAGES];
   logic [TAG_W-1:0] tag_p   [STAGES];

   logic [BITS-1:0]  src_a   [STAGES];
   logic [BITS-1:0]  src_b   [STAGES];
   logic [BITS-1:0]  src_res [STAGES];
   logic             src_cy  [STAGES];
   logic [TAG_W-1:0] src_tag [STAGES];
   logic [BITS-1:0]  nxt_res [STAGES];
   logic [CW-1:0]    sum     [STAGES];
   logic             cout    [STAGES];
   logic             cmsb    [STAGES];

   flags_t flags_q;

   function automatic flags_t calc_flags(input logic [BITS-1:0] r,
                                         input logic c_msb,
                                         input logic c_out);
      flags_t f;
      f.n = r[BITS-1];
      f.z = (r == '0);
      f.v = c_msb ^ c_out;
      f.c = c_out;
      return f;
   endfunction

   assign cin0 = (op_e'(sub) == OP_SUB);

   always_comb begin
      rdy = '0;
      rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = !vld[k] || rdy[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign src_vld[k] = in_valid;
         assign src_a[k]   = a;
         assign src_b[k]   = cin0 ? ~b : b;
         assign src_res[k] = '0;
         assign src_cy[k]  = cin0;
         assign src_tag[k] = in_tag;
      end else begin : g_body
         assign src_vld[k] = vld[k-1];
         assign src_a[k]   = a_p[k-1];
         assign src_b[k]   = b_p[k-1];
         assign src_res[k] = res_p[k-1];
         assign src_cy[k]  = cy_p[k-1];
         assign src_tag[k] = tag_p[k-1];
      end

      addsub_chunk #(.CW(CW)) u_chunk (
         .x    (src_a[k][k*CW +: CW]),
         .y    (src_b[k][k*CW +: CW]),
         .cin  (src_cy[k]),
         .sum  (sum[k]),
         .cout (cout[k]),
         .cmsb (cmsb[k])
      );
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         nxt_res[k] = src_res[k];
         nxt_res[k][k*CW +: CW] = sum[k];
      end
   end

   // Data moves only on a transfer into a stage; valid bits follow the ready chain.
   always_ff @(posedge clk) begin
      for (int k = 0; k < STAGES; k++) begin
         if (rdy[k] && src_vld[k]) begin
            a_p[k]   <= src_a[k];
            b_p[k]   <= src_b[k];
            res_p[k] <= nxt_res[k];
            cy_p[k]  <= cout[k];
            tag_p[k] <= src_tag[k];
         end
      end
      if (rdy[STAGES-1] && src_vld[STAGES-1]) begin
         flags_q <= calc_flags(nxt_res[STAGES-1], cmsb[STAGES-1], cout[STAGES-1]);
      end
      if (!reset) begin
         vld               <= '0;
         res_p[STAGES-1]   <= '0;
         tag_p[STAGES-1]   <= '0;
         flags_q           <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) vld[k] <= src_vld[k];
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld[STAGES-1];
   assign result    = res_p[STAGES-1];
   assign out_tag   = tag_p[STAGES-1];
   assign flags     = flags_q;

endmodule
